// File: rtl/pwmdir_capture.sv
// rtl/pwmdir_capture.sv - PWM/DIR receiver: signed duty and period counts per PWM cycle
// Optional input glitch filter: define PWMDIR_GLITCH_FILTER_EN.
module pwmdir_capture #(
  parameter int unsigned TIMEOUT    = 200000,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jointEnable,
  input  logic        PWM,
  input  logic        DIR,
  output logic [31:0] dutyCount,
  output logic [31:0] periodCount,
  output logic        valid,
  output logic        stale
);

  localparam logic [31:0] TO = 32'(TIMEOUT);

  if (FILTER_LEN < 1) begin : g_len_check
    $error("FILTER_LEN must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_nxt;

  logic        pwm_p1, dir_p1;
  logic        pwm_lvl, dir_lvl, pwm_prev;
  logic        rise, fall, any_edge, to_hit, publish;
  logic [31:0] period_cnt, high_cnt, idle_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic pos);
    return pos ? mag : (~mag + 32'd1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p1 <= 1'b0;
      dir_p1 <= 1'b0;
    end else begin
      pwm_p1 <= PWM;
      dir_p1 <= DIR;
    end
  end

`ifdef PWMDIR_GLITCH_FILTER_EN
  // Level only moves after FILTER_LEN identical p1 samples; both edges see the same delay.
  logic [FILTER_LEN-1:0] pwm_hist, dir_hist;
  logic                  pwm_flt, dir_flt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_hist <= '0;
      dir_hist <= '0;
      pwm_flt  <= 1'b0;
      dir_flt  <= 1'b0;
    end else begin
      pwm_hist <= FILTER_LEN'({pwm_hist, pwm_p1});
      dir_hist <= FILTER_LEN'({dir_hist, dir_p1});
      if (&pwm_hist)       pwm_flt <= 1'b1;
      else if (~|pwm_hist) pwm_flt <= 1'b0;
      if (&dir_hist)       dir_flt <= 1'b1;
      else if (~|dir_hist) dir_flt <= 1'b0;
    end
  end

  assign pwm_lvl = pwm_flt;
  assign dir_lvl = dir_flt;
`else
  logic pwm_p2, dir_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p2 <= 1'b0;
      dir_p2 <= 1'b0;
    end else begin
      pwm_p2 <= pwm_p1;
      dir_p2 <= dir_p1;
    end
  end

  assign pwm_lvl = pwm_p2;
  assign dir_lvl = dir_p2;
`endif

  assign rise     = pwm_lvl & ~pwm_prev;
  assign fall     = ~pwm_lvl & pwm_prev;
  assign any_edge = rise | fall;
  // An edge on the timeout cycle restarts the idle count, so it takes priority.
  assign to_hit   = ~any_edge && (idle_cnt == TO - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    case (state)
      IDLE: if (rise) state_nxt = HIGH;
      HIGH: if (fall) state_nxt = LOW;
      LOW: begin
        if (rise) begin
          state_nxt = HIGH;
          publish   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (to_hit)       state_nxt = IDLE;
    if (!jointEnable) begin
      state_nxt = IDLE;
      publish   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_prev    <= 1'b0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      idle_cnt    <= '0;
      dutyCount   <= '0;
      periodCount <= '0;
      valid       <= 1'b0;
      stale       <= 1'b1;
    end else begin
      pwm_prev <= pwm_lvl;
      valid    <= 1'b0;
      if (!jointEnable) begin
        period_cnt  <= '0;
        high_cnt    <= '0;
        idle_cnt    <= '0;
        dutyCount   <= '0;
        periodCount <= '0;
        stale       <= 1'b1;
      end else begin
        if (any_edge)           idle_cnt <= '0;
        else if (idle_cnt < TO) idle_cnt <= idle_cnt + 32'd1;

        if (to_hit) begin
          valid       <= 1'b1;
          stale       <= 1'b1;
          period_cnt  <= '0;
          high_cnt    <= '0;
          dutyCount   <= pwm_lvl ? apply_sign(TO, dir_lvl) : 32'd0;
          periodCount <= pwm_lvl ? TO : 32'd0;
        end else if (publish) begin
          valid       <= 1'b1;
          stale       <= 1'b0;
          dutyCount   <= apply_sign(high_cnt, dir_lvl);
          periodCount <= period_cnt;
          period_cnt  <= 32'd1;
          high_cnt    <= 32'd1;
        end else begin
          case (state)
            IDLE: begin
              if (rise) begin
                period_cnt <= 32'd1;
                high_cnt   <= 32'd1;
              end
            end
            HIGH: begin
              period_cnt <= sat_inc(period_cnt);
              if (!fall) high_cnt <= sat_inc(high_cnt);
            end
            LOW:     period_cnt <= sat_inc(period_cnt);
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pwmdir_capture.sv
// tb/tb_pwmdir_capture.sv - scoreboard bench for pwmdir_capture (default build)
module tb_pwmdir_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jointEnable = 1'b1;
  logic        PWM = 1'b0;
  logic        DIR = 1'b1;
  logic [31:0] dutyCount, periodCount;
  logic        valid, stale;

  typedef struct {
    logic [31:0] duty;
    logic [31:0] period;
    logic        stale;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  pwmdir_capture #(.TIMEOUT(1000), .FILTER_LEN(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .jointEnable (jointEnable),
    .PWM         (PWM),
    .DIR         (DIR),
    .dutyCount   (dutyCount),
    .periodCount (periodCount),
    .valid       (valid),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] p, input logic s);
    exp_t e;
    e.duty   = d;
    e.period = p;
    e.stale  = s;
    sb.push_back(e);
  endtask

  // One PWM cycle: h high, l low; DIR changes mid-high so it signs the publish closing this cycle.
  task automatic period(input int h, input int l, input logic d, input bit pub);
    if (pub) push(d ? 32'(h) : 32'(-h), 32'(h + l), 1'b0);
    PWM = 1'b1;
    repeat (h / 2) @(negedge clk);
    DIR = d;
    repeat (h - h / 2) @(negedge clk);
    PWM = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid got duty=%h period=%h expected no publish",
                   dutyCount, periodCount);
        end else begin
          e = sb.pop_front();
          chk("pub_duty", dutyCount, e.duty);
          chk("pub_period", periodCount, e.period);
          chk("pub_stale", 32'(stale), 32'(e.stale));
        end
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_duty", dutyCount, 32'd0);
    chk("rst_period", periodCount, 32'd0);
    chk("rst_stale", 32'(stale), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) period(30, 70, 1'b1, 1'b1);
    period(30, 70, 1'b0, 1'b1);
    period(30, 70, 1'b0, 1'b1);
    period(30, 70, 1'b1, 1'b1);

    // Unfiltered 2-cycle low glitch splits one cycle into two short publishes.
    period(10, 2, 1'b1, 1'b1);
    period(18, 70, 1'b1, 1'b1);

    PWM = 1'b1;
    repeat (30) @(negedge clk);
    PWM = 1'b0;
    push(32'd0, 32'd0, 1'b1);
    repeat (1300) @(negedge clk);
    chk("to_low_stale", 32'(stale), 32'd1);
    chk("to_low_duty", dutyCount, 32'd0);

    DIR = 1'b1;
    PWM = 1'b1;
    push(32'd1000, 32'd1000, 1'b1);
    repeat (1300) @(negedge clk);
    chk("to_high_duty", dutyCount, 32'd1000);
    chk("to_high_period", periodCount, 32'd1000);

    PWM = 1'b0;
    repeat (50) @(negedge clk);
    period(30, 70, 1'b1, 1'b1);
    PWM = 1'b1;
    repeat (10) @(negedge clk);
    jointEnable = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_duty", dutyCount, 32'd0);
    chk("dis_period", periodCount, 32'd0);
    chk("dis_stale", 32'(stale), 32'd1);
    chk("dis_valid", 32'(valid), 32'd0);

    jointEnable = 1'b1;
    PWM = 1'b0;
    repeat (20) @(negedge clk);
    period(30, 70, 1'b1, 1'b1);
    period(30, 70, 1'b0, 1'b1);
    PWM = 1'b1;
    repeat (15) @(negedge clk);
    chk("pre_rst_duty", dutyCount, 32'hFFFF_FFE2);

    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", dutyCount, 32'd0);
    chk("mid_rst_period", periodCount, 32'd0);
    chk("mid_rst_stale", 32'(stale), 32'd1);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
